// File: rtl/matrix_icon_scanner_pkg.sv
// Shared encodings, FSM state type, level thresholds and default 8x5 mode bitmaps
// for the LED matrix icon scanner.
package matrix_icon_scanner_pkg;

    typedef enum logic [1:0] {
        NIVEL_CRITICO = 2'd0,
        NIVEL_BAIXO   = 2'd1,
        NIVEL_MEDIO   = 2'd2,
        NIVEL_ALTO    = 2'd3
    } nivel_e;

    typedef enum logic [1:0] {
        MODO_NONE        = 2'd0,
        MODO_ASPERSAO    = 2'd1,
        MODO_GOTEJAMENTO = 2'd2,
        MODO_RESERVED    = 2'd3
    } modo_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW_LEVEL,
        ST_SHOW_MODE
    } state_e;

    // Level icons share their low bits with nivel_e so the id is {0, nivel}.
    typedef enum logic [2:0] {
        ICON_CRITICO     = 3'd0,
        ICON_BAIXO       = 3'd1,
        ICON_MEDIO       = 3'd2,
        ICON_ALTO        = 3'd3,
        ICON_ASPERSAO    = 3'd4,
        ICON_GOTEJAMENTO = 3'd5,
        ICON_BLANK       = 3'd6
    } icon_e;

    // Rows counted back from the bottom row at which the interior fill starts.
    localparam int THR_OFS_CRITICO = 1;
    localparam int THR_OFS_BAIXO   = 3;
    localparam int THR_OFS_MEDIO   = 5;

    localparam int BMP_ROWS = 8;
    localparam int BMP_COLS = 5;

    // Packed as {row7, ..., row0}; bit c of a row is column c.
    localparam logic [BMP_ROWS-1:0][BMP_COLS-1:0] BMP_ASPERSAO = {
        5'b00100, 5'b00100, 5'b10101, 5'b01110,
        5'b11111, 5'b01110, 5'b10101, 5'b00100
    };

    localparam logic [BMP_ROWS-1:0][BMP_COLS-1:0] BMP_GOTEJAMENTO = {
        5'b00000, 5'b01110, 5'b11111, 5'b11111,
        5'b01110, 5'b01110, 5'b00100, 5'b00100
    };

    function automatic int level_threshold(input nivel_e lvl, input int num_rows);
        case (lvl)
            NIVEL_CRITICO: return num_rows - THR_OFS_CRITICO;
            NIVEL_BAIXO:   return num_rows - THR_OFS_BAIXO;
            NIVEL_MEDIO:   return num_rows - THR_OFS_MEDIO;
            default:       return 0;
        endcase
    endfunction

    function automatic logic mode_has_icon(input modo_e m);
        return (m == MODO_ASPERSAO) || (m == MODO_GOTEJAMENTO);
    endfunction

endpackage

// File: rtl/matrix_icon_scanner_if.sv
// Control inputs and matrix drive outputs of the icon scanner.
interface matrix_icon_scanner_if
    import matrix_icon_scanner_pkg::*;
#(
    parameter int NUM_ROWS = 8,
    parameter int NUM_COLS = 5
) ();
    logic                        enable;
    nivel_e                      nivel;
    modo_e                       modo;
    logic [NUM_ROWS-1:0]         row_sel;
    logic [NUM_COLS-1:0]         col_data;
    logic [$clog2(NUM_ROWS)-1:0] row_idx;
    logic                        frame_start;
    logic                        showing_mode;

    modport master (
        output enable, nivel, modo,
        input  row_sel, col_data, row_idx, frame_start, showing_mode
    );

    modport slave (
        input  enable, nivel, modo,
        output row_sel, col_data, row_idx, frame_start, showing_mode
    );
endinterface

// File: rtl/matrix_icon_scanner_icon_rom.sv
// Combinational icon bitmap lookup: icon id and row -> column pattern.
module icon_rom
    import matrix_icon_scanner_pkg::*;
#(
    parameter int NUM_ROWS = 8,
    parameter int NUM_COLS = 5
) (
    input  icon_e                       icon,
    input  logic [$clog2(NUM_ROWS)-1:0] row,
    output logic [NUM_COLS-1:0]         cols
);
    localparam int MAP_ROWS = (NUM_ROWS < BMP_ROWS) ? NUM_ROWS : BMP_ROWS;
    localparam int MAP_COLS = (NUM_COLS < BMP_COLS) ? NUM_COLS : BMP_COLS;

    logic [BMP_COLS-1:0] bmp_row;
    int                  thr;

    // Level icons are a frame with an interior fill from the threshold row down;
    // mode icons come from the package bitmaps, clipped to the matrix size.
    always_comb begin
        cols    = '0;
        bmp_row = '0;
        thr     = 0;
        if (int'(row) < MAP_ROWS) begin
            if (icon == ICON_ASPERSAO)
                bmp_row = BMP_ASPERSAO[row[2:0]];
            else if (icon == ICON_GOTEJAMENTO)
                bmp_row = BMP_GOTEJAMENTO[row[2:0]];
        end
        case (icon)
            ICON_CRITICO, ICON_BAIXO, ICON_MEDIO, ICON_ALTO: begin
                thr = level_threshold(nivel_e'(icon[1:0]), NUM_ROWS);
                for (int c = 0; c < NUM_COLS; c++)
                    cols[c] = (c == 0) || (c == NUM_COLS - 1) || (int'(row) >= thr);
            end
            ICON_ASPERSAO, ICON_GOTEJAMENTO: begin
                for (int c = 0; c < MAP_COLS; c++)
                    cols[c] = bmp_row[c];
            end
            default: cols = '0;
        endcase
    end
endmodule

// File: rtl/matrix_icon_scanner.sv
// Row-multiplexed LED matrix scanner showing a tank level icon that alternates
// with an irrigation mode icon, with a blinking critical level.
//
// state         | meaning
// ST_IDLE       | display dark, all counters held at 0
// ST_SHOW_LEVEL | scanning the level icon (blanked on odd blink phase when critico)
// ST_SHOW_MODE  | scanning the aspersao / gotejamento icon
module matrix_icon_scanner
    import matrix_icon_scanner_pkg::*;
#(
    parameter int NUM_ROWS     = 8,
    parameter int NUM_COLS     = 5,
    parameter int SCAN_DIV     = 1000,
    parameter int ALT_FRAMES   = 50,
    parameter int BLINK_FRAMES = 25
) (
    input logic                   clk,
    input logic                   reset,
    matrix_icon_scanner_if.slave  bus
);
    localparam int ROW_W   = $clog2(NUM_ROWS);
    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    state_e              state, nxt_state;
    nivel_e              nivel_s, nxt_nivel;
    modo_e               modo_s, nxt_modo;
    logic [PRESC_W-1:0]  presc;
    logic [ROW_W-1:0]    row_cnt, nxt_row;
    logic [FRAME_W-1:0]  frame_cnt, nxt_frame_cnt;
    logic [BLINK_W-1:0]  blink_cnt, nxt_blink_cnt;
    logic                blink_phase, nxt_phase;
    logic                row_tick, frame_wrap, alt_done;
    icon_e               icon;
    logic [NUM_COLS-1:0] icon_cols;
    logic [NUM_ROWS-1:0] row_sel_q;
    logic [NUM_COLS-1:0] col_data_q;
    logic                frame_start_q, showing_mode_q;

    // Next displayed view: row, sampled inputs, state and blink phase after this edge.
    always_comb begin
        row_tick      = (presc == PRESC_W'(SCAN_DIV - 1));
        frame_wrap    = (state != ST_IDLE) && row_tick && (row_cnt == ROW_W'(NUM_ROWS - 1));
        alt_done      = (frame_cnt == FRAME_W'(ALT_FRAMES - 1));
        nxt_state     = state;
        nxt_nivel     = nivel_s;
        nxt_modo      = modo_s;
        nxt_phase     = blink_phase;
        nxt_row       = row_cnt + ROW_W'(1);
        nxt_frame_cnt = frame_cnt;
        nxt_blink_cnt = blink_cnt;
        if (state == ST_IDLE) begin
            nxt_state     = ST_SHOW_LEVEL;
            nxt_nivel     = bus.nivel;
            nxt_modo      = bus.modo;
            nxt_phase     = 1'b0;
            nxt_row       = '0;
            nxt_frame_cnt = '0;
            nxt_blink_cnt = '0;
        end else if (frame_wrap) begin
            nxt_nivel = bus.nivel;
            nxt_modo  = bus.modo;
            nxt_row   = '0;
            case (state)
                ST_SHOW_LEVEL: if (alt_done && mode_has_icon(nxt_modo)) nxt_state = ST_SHOW_MODE;
                ST_SHOW_MODE:  if (alt_done || !mode_has_icon(nxt_modo)) nxt_state = ST_SHOW_LEVEL;
                default:       nxt_state = state;
            endcase
            nxt_frame_cnt = (nxt_state != state || alt_done) ? '0 : frame_cnt + FRAME_W'(1);
            if (nxt_nivel != NIVEL_CRITICO) begin
                nxt_phase     = 1'b0;
                nxt_blink_cnt = '0;
            end else if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                nxt_phase     = ~blink_phase;
                nxt_blink_cnt = '0;
            end else begin
                nxt_blink_cnt = blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Icon to show for the next view; a critico level on the odd blink phase goes dark.
    always_comb begin
        icon = ICON_BLANK;
        if (nxt_state == ST_SHOW_MODE) begin
            if (nxt_modo == MODO_ASPERSAO)
                icon = ICON_ASPERSAO;
            else if (nxt_modo == MODO_GOTEJAMENTO)
                icon = ICON_GOTEJAMENTO;
        end else if (!(nxt_nivel == NIVEL_CRITICO && nxt_phase)) begin
            icon = icon_e'({1'b0, nxt_nivel});
        end
    end

    icon_rom #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_icon_rom (
        .icon (icon),
        .row  (nxt_row),
        .cols (icon_cols)
    );

    // FSM, counters and registered matrix drive; all outputs change on the same edge.
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            state          <= ST_IDLE;
            nivel_s        <= NIVEL_CRITICO;
            modo_s         <= MODO_NONE;
            presc          <= '0;
            row_cnt        <= '0;
            frame_cnt      <= '0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            row_sel_q      <= '0;
            col_data_q     <= '0;
            frame_start_q  <= 1'b0;
            showing_mode_q <= 1'b0;
        end else begin
            presc         <= (state == ST_IDLE || row_tick) ? '0 : presc + PRESC_W'(1);
            frame_start_q <= frame_wrap;
            if (state == ST_IDLE || row_tick) begin
                state          <= nxt_state;
                nivel_s        <= nxt_nivel;
                modo_s         <= nxt_modo;
                blink_phase    <= nxt_phase;
                frame_cnt      <= nxt_frame_cnt;
                blink_cnt      <= nxt_blink_cnt;
                row_cnt        <= nxt_row;
                row_sel_q      <= NUM_ROWS'(1) << nxt_row;
                col_data_q     <= icon_cols;
                showing_mode_q <= (nxt_state == ST_SHOW_MODE);
            end
        end
    end

    assign bus.row_sel      = row_sel_q;
    assign bus.col_data     = col_data_q;
    assign bus.row_idx      = row_cnt;
    assign bus.frame_start  = frame_start_q;
    assign bus.showing_mode = showing_mode_q;

endmodule
